// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and line idle level.
// Used by uart_tx today and intended for the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_e;

    // 100 MHz system clock, 115200 baud
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// FIFO read handshake between uart_tx (master, issues pops) and the upstream transmit FIFO.
// Read data is valid on fifo_data_i the cycle after fifo_rd_en_o is high.
interface uart_tx_if #(
    parameter int unsigned DataBits = 8
);
    logic                fifo_empty_i;
    logic                fifo_rd_en_o;
    logic [DataBits-1:0] fifo_data_i;

    modport master (
        input  fifo_empty_i,
        input  fifo_data_i,
        output fifo_rd_en_o
    );

    modport slave (
        output fifo_empty_i,
        output fifo_data_i,
        input  fifo_rd_en_o
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..ClksPerBit-1 and pulses bit_done on the last cycle of each bit.
// clr holds the counter at zero so the first bit after it is a full period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned ClksPerBit = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr,
    output logic bit_done
);

    localparam int unsigned     CntW    = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

    logic [CntW-1:0] cnt_reg;
    logic [CntW-1:0] cnt_next;
    logic            at_last;

    assign at_last  = (cnt_reg == CntLast);
    assign bit_done = at_last && !clr;

    always_comb begin
        cnt_next = cnt_reg + CntW'(1);
        if (clr || at_last) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops one word per frame from an upstream FIFO and sends
// start / data (LSB first) / optional parity / stop. Parity: define UART_TX_PARITY_EN.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned ClksPerBit = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DataBits   = 8,
    parameter int unsigned StopBits   = 1,
    parameter int unsigned ParityOdd  = 0
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    uart_tx_if.master fifo,
    output logic      tx_o,
    output logic      busy_o
);

    if (ClksPerBit < 2 || DataBits < 5 || DataBits > 8 ||
        (StopBits != 1 && StopBits != 2) || ParityOdd > 1) begin : g_bad_cfg
        $error("uart_tx: unsupported parameter combination");
    end

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] FETCH  = ST_FETCH;
    localparam logic [2:0] START  = ST_START;
    localparam logic [2:0] DATA   = ST_DATA;
    localparam logic [2:0] STOP   = ST_STOP;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = ST_PARITY;
`endif

    localparam int unsigned        BitCntW  = 3;
    localparam logic [BitCntW-1:0] LastData = BitCntW'(DataBits - 1);
    localparam logic [BitCntW-1:0] LastStop = BitCntW'(StopBits - 1);

    logic [2:0]          state_reg;
    logic [2:0]          state_next;
    logic [DataBits-1:0] shift_reg;
    logic [DataBits-1:0] shift_next;
    logic [BitCntW-1:0]  bit_cnt_reg;
    logic [BitCntW-1:0]  bit_cnt_next;
    logic                tx_reg;
    logic                tx_next;
    logic                ready_reg;
    logic                pop;
    logic                bit_done;
    logic                baud_clr;

    // ready_reg holds off the first pop until the first clock edge after reset release
    assign pop               = ready_reg && (state_reg == IDLE) && !fifo.fifo_empty_i;
    assign fifo.fifo_rd_en_o = pop;
    assign baud_clr          = (state_reg == IDLE) || (state_reg == FETCH);
    assign busy_o            = (state_reg != IDLE);
    assign tx_o              = tx_reg;

    uart_baud_gen #(
        .ClksPerBit (ClksPerBit)
    ) u_baud_gen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr      (baud_clr),
        .bit_done (bit_done)
    );

`ifdef UART_TX_PARITY_EN
    logic                parity_reg;
    logic                parity_next;
    logic [DataBits:0]   par_chain;

    // Seeding the XOR chain with ParityOdd yields odd parity directly
    assign par_chain[0] = 1'(ParityOdd);
    for (genvar gi = 0; gi < DataBits; gi++) begin : g_par
        assign par_chain[gi+1] = par_chain[gi] ^ fifo.fifo_data_i[gi];
    end
`endif

    // Next tx level is decided together with the transition so tx_reg changes on the bit boundary
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        tx_next      = tx_reg;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                tx_next = LINE_IDLE;
                if (pop) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                shift_next   = fifo.fifo_data_i;
                bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                parity_next  = par_chain[DataBits];
`endif
                tx_next      = 1'b0;
                state_next   = START;
            end
            START: begin
                if (bit_done) begin
                    tx_next    = shift_reg[0];
                    shift_next = shift_reg >> 1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_reg == LastData) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        tx_next      = parity_reg;
                        state_next   = PARITY;
`else
                        tx_next      = LINE_IDLE;
                        state_next   = STOP;
`endif
                    end else begin
                        tx_next      = shift_reg[0];
                        shift_next   = shift_reg >> 1;
                        bit_cnt_next = bit_cnt_reg + BitCntW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    tx_next    = LINE_IDLE;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (bit_cnt_reg == LastStop) begin
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BitCntW'(1);
                    end
                end
            end
            default: begin
                tx_next    = LINE_IDLE;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            tx_reg      <= LINE_IDLE;
            ready_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            tx_reg      <= tx_next;
            ready_reg   <= 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= parity_next;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (8N1 even, 7-bit/2-stop odd) fed from queue FIFOs,
// checked cycle by cycle against a frame-schedule model and a mid-bit sampling decoder.
module tb_uart_tx;

    localparam int C     = 4;
    localparam int DA    = 8;
    localparam int SA    = 1;
    localparam int DB    = 7;
    localparam int SB    = 2;
    localparam int N_MAX = 512;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } push_t;

    logic clk = 1'b0;
    logic rst_n;
    logic tx_a, busy_a, tx_b, busy_b;

    uart_tx_if #(.DataBits(DA)) if_a ();
    uart_tx_if #(.DataBits(DB)) if_b ();

    uart_tx #(.ClksPerBit(C), .DataBits(DA), .StopBits(SA), .ParityOdd(0)) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .fifo   (if_a),
        .tx_o   (tx_a),
        .busy_o (busy_a)
    );

    uart_tx #(.ClksPerBit(C), .DataBits(DB), .StopBits(SB), .ParityOdd(1)) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .fifo   (if_b),
        .tx_o   (tx_b),
        .busy_o (busy_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    push_t push_a[$];
    push_t push_b[$];
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int pops_a, pops_b;
    logic [N_MAX-1:0] o_tx_a, o_busy_a, o_rd_a, o_tx_b, o_busy_b, o_rd_b;
    logic [N_MAX-1:0] e_tx, e_busy, e_rd;

    task automatic check(input string tag, input logic [N_MAX-1:0] obs, input logic [N_MAX-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_push(input int which, input int cyc, input logic [7:0] d);
        push_t p;
        p.cyc  = cyc;
        p.data = d;
        if (which == 0) push_a.push_back(p);
        else            push_b.push_back(p);
    endtask

    // Line level k cycles into a frame: start, data LSB first, optional parity, stop
    function automatic logic frame_bit(input logic [7:0] data, input int d, input int odd, input int k);
        int slot;
        logic [7:0] m;
        slot = k / C;
        m = data & 8'((1 << d) - 1);
        if (slot == 0) return 1'b0;
        if (slot <= d) return m[slot-1];
        if (PAR == 1 && slot == d + 1) return 1'(($countones(m) + odd) % 2);
        return 1'b1;
    endfunction

    // Frame schedule: a word pops when it is present and the line is free; the line
    // is free again two cycles (pop + fetch) plus one frame after the pop.
    task automatic build_expect(input push_t pl[$], input int d, input int s, input int odd, input int n,
                                output logic [N_MAX-1:0] etx, output logic [N_MAX-1:0] ebusy,
                                output logic [N_MAX-1:0] erd);
        int free, pop, len;
        len   = C * (1 + d + PAR + s);
        etx   = '1;
        ebusy = '0;
        erd   = '0;
        free  = 0;
        foreach (pl[i]) begin
            pop = (pl[i].cyc > free) ? pl[i].cyc : free;
            if (pop < n) erd[pop] = 1'b1;
            for (int c = pop + 1; c <= pop + 1 + len && c < n; c++) ebusy[c] = 1'b1;
            for (int k = 0; k < len && pop + 2 + k < n; k++) etx[pop + 2 + k] = frame_bit(pl[i].data, d, odd, k);
            free = pop + 2 + len;
        end
    endtask

    function automatic int next_low(input logic [N_MAX-1:0] tr, input int from, input int n);
        for (int i = from; i < n; i++) if (tr[i] == 1'b0) return i;
        return -1;
    endfunction

    task automatic decode_check(input string tag, input logic [N_MAX-1:0] tr, input int n,
                                input int d, input int s, input push_t pl[$]);
        int i, idx, len;
        logic [7:0] got, m;
        len = C * (1 + d + PAR + s);
        m   = 8'((1 << d) - 1);
        i   = 0;
        idx = 0;
        while (i < n) begin
            if (tr[i] == 1'b0 && i + len <= n) begin
                got = '0;
                for (int j = 0; j < d; j++) got[j] = tr[i + C * (1 + j) + C / 2];
                $display("%s: frame %0d at cycle %0d decoded %02h", tag, idx, i, got);
                if (idx < pl.size()) check($sformatf("%s decode%0d", tag, idx), N_MAX'(got), N_MAX'(pl[idx].data & m));
                idx++;
                i += len;
            end else begin
                i++;
            end
        end
        check({tag, " frames"}, N_MAX'(idx), N_MAX'(pl.size()));
    endtask

    task automatic do_reset();
        q_a.delete();
        q_b.delete();
        if_a.fifo_empty_i = 1'b1;
        if_b.fifo_empty_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        o_tx_a = '1; o_busy_a = '0; o_rd_a = '0;
        o_tx_b = '1; o_busy_b = '0; o_rd_b = '0;
        pops_a = 0;
        pops_b = 0;
    endtask

    // Cycle c starts 1 time unit after a rising edge; outputs are sampled on the falling edge
    task automatic run_cycles(input int n);
        logic rda, rdb;
        for (int c = 0; c < n; c++) begin
            foreach (push_a[i]) if (push_a[i].cyc == c) q_a.push_back(push_a[i].data);
            foreach (push_b[i]) if (push_b[i].cyc == c) q_b.push_back(push_b[i].data);
            if_a.fifo_empty_i = (q_a.size() == 0);
            if_b.fifo_empty_i = (q_b.size() == 0);
            @(negedge clk);
            if (c < N_MAX) begin
                o_tx_a[c] = tx_a;  o_busy_a[c] = busy_a;  o_rd_a[c] = if_a.fifo_rd_en_o;
                o_tx_b[c] = tx_b;  o_busy_b[c] = busy_b;  o_rd_b[c] = if_b.fifo_rd_en_o;
            end
            rda = if_a.fifo_rd_en_o;
            rdb = if_b.fifo_rd_en_o;
            @(posedge clk);
            #1;
            if_a.fifo_data_i = DA'($urandom);
            if_b.fifo_data_i = DB'($urandom);
            if (rda === 1'b1) begin
                pops_a++;
                if (q_a.size() > 0) if_a.fifo_data_i = q_a.pop_front();
            end
            if (rdb === 1'b1) begin
                pops_b++;
                if (q_b.size() > 0) if_b.fifo_data_i = DB'(q_b.pop_front());
            end
        end
        if_a.fifo_empty_i = (q_a.size() == 0);
        if_b.fifo_empty_i = (q_b.size() == 0);
    endtask

    task automatic run_scenario(input string tag, input int n);
        do_reset();
        run_cycles(n);
        build_expect(push_a, DA, SA, 0, n, e_tx, e_busy, e_rd);
        check({tag, " tx_a"},   o_tx_a,   e_tx);
        check({tag, " busy_a"}, o_busy_a, e_busy);
        check({tag, " rd_a"},   o_rd_a,   e_rd);
        check({tag, " pops_a"}, N_MAX'(pops_a), N_MAX'(push_a.size()));
        decode_check({tag, " a"}, o_tx_a, n, DA, SA, push_a);
        build_expect(push_b, DB, SB, 1, n, e_tx, e_busy, e_rd);
        check({tag, " tx_b"},   o_tx_b,   e_tx);
        check({tag, " busy_b"}, o_busy_b, e_busy);
        check({tag, " rd_b"},   o_rd_b,   e_rd);
        check({tag, " pops_b"}, N_MAX'(pops_b), N_MAX'(push_b.size()));
        decode_check({tag, " b"}, o_tx_b, n, DB, SB, push_b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s1, s2, cyc, len_a, len_b;
        len_a = C * (1 + DA + PAR + SA);
        len_b = C * (1 + DB + PAR + SB);

        // Reset held with a non-empty FIFO: no pop, idle line
        rst_n = 1'b0;
        if_a.fifo_empty_i = 1'b0;
        if_b.fifo_empty_i = 1'b0;
        if_a.fifo_data_i  = '0;
        if_b.fifo_data_i  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset tx_a",   N_MAX'(tx_a),   N_MAX'(1));
        check("reset busy_a", N_MAX'(busy_a), N_MAX'(0));
        check("reset rd_a",   N_MAX'(if_a.fifo_rd_en_o), N_MAX'(0));
        check("reset tx_b",   N_MAX'(tx_b),   N_MAX'(1));
        check("reset busy_b", N_MAX'(busy_b), N_MAX'(0));
        check("reset rd_b",   N_MAX'(if_b.fifo_rd_en_o), N_MAX'(0));

        // Single frames: 0x55 on the 8-bit unit, 0x7F on the 7-bit two-stop unit
        push_a.delete(); push_b.delete();
        add_push(0, 0, 8'h55);
        add_push(1, 0, 8'h7F);
        run_scenario("single", 80);

        // Back-to-back frames with a 2-cycle idle gap
        push_a.delete(); push_b.delete();
        add_push(0, 0, 8'hA3);
        add_push(0, 0, 8'h0F);
        add_push(1, 0, 8'h2A);
        add_push(1, 0, 8'h55);
        run_scenario("b2b", 120);
        s1 = next_low(o_tx_a, 0, 120);
        s2 = next_low(o_tx_a, s1 + len_a, 120);
        check("b2b gap_a", N_MAX'(s2 - (s1 + len_a)), N_MAX'(2));
        s1 = next_low(o_tx_b, 0, 120);
        s2 = next_low(o_tx_b, s1 + len_b, 120);
        check("b2b gap_b", N_MAX'(s2 - (s1 + len_b)), N_MAX'(2));

        // Reset in the middle of DATA
        push_a.delete(); push_b.delete();
        add_push(0, 0, 8'hFF);
        add_push(1, 0, 8'h00);
        do_reset();
        run_cycles(12);
        #2;
        check("midrst busy_a before", N_MAX'(busy_a), N_MAX'(1));
        check("midrst busy_b before", N_MAX'(busy_b), N_MAX'(1));
        check("midrst tx_b before",   N_MAX'(tx_b),   N_MAX'(0));
        q_a.push_back(8'h11);
        q_b.push_back(8'h22);
        if_a.fifo_empty_i = 1'b0;
        if_b.fifo_empty_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst tx_a",   N_MAX'(tx_a),   N_MAX'(1));
        check("midrst busy_a", N_MAX'(busy_a), N_MAX'(0));
        check("midrst rd_a",   N_MAX'(if_a.fifo_rd_en_o), N_MAX'(0));
        check("midrst tx_b",   N_MAX'(tx_b),   N_MAX'(1));
        check("midrst busy_b", N_MAX'(busy_b), N_MAX'(0));
        check("midrst rd_b",   N_MAX'(if_b.fifo_rd_en_o), N_MAX'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("inrst rd_a", N_MAX'(if_a.fifo_rd_en_o), N_MAX'(0));
        check("inrst rd_b", N_MAX'(if_b.fifo_rd_en_o), N_MAX'(0));
        q_a.delete(); q_b.delete();
        if_a.fifo_empty_i = 1'b1;
        if_b.fifo_empty_i = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("postrst%0d rd_a", k), N_MAX'(if_a.fifo_rd_en_o), N_MAX'(0));
            check($sformatf("postrst%0d tx_a", k), N_MAX'(tx_a), N_MAX'(1));
            check($sformatf("postrst%0d busy_a", k), N_MAX'(busy_a), N_MAX'(0));
            check($sformatf("postrst%0d rd_b", k), N_MAX'(if_b.fifo_rd_en_o), N_MAX'(0));
        end
        check("midrst pops_a", N_MAX'(pops_a), N_MAX'(1));
        check("midrst pops_b", N_MAX'(pops_b), N_MAX'(1));

        // Random words arriving at random times
        for (int r = 0; r < 3; r++) begin
            push_a.delete(); push_b.delete();
            cyc = 0;
            for (int k = 0; k < 4; k++) begin
                cyc += $urandom_range(0, 60);
                add_push(0, cyc, 8'($urandom));
            end
            cyc = 0;
            for (int k = 0; k < 4; k++) begin
                cyc += $urandom_range(0, 60);
                add_push(1, cyc, 8'($urandom));
            end
            run_scenario($sformatf("random%0d", r), 440);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
